camac_cycle_sequencer: RTL and testbench
========================================

CAMAC_CYCLE_SEQUENCER -- requirements
Module: camac_cycle_sequencer

Interface
REQ-001 Parameter T_SETUP, default 2: isa_clk cycles of N/A/F/W setup before S1 (legal 1..15).
REQ-002 Parameter T_S1, default 2: S1 strobe width in cycles (legal 1..15).
REQ-003 Parameter T_GAP, default 2: cycles between S1 fall and S2 rise (legal 1..15).
REQ-004 Parameter T_S2, default 2: S2 strobe width in cycles (legal 1..15).
REQ-005 Parameter T_HOLD, default 1: cycles of N/A/F/W hold after S2 (legal 1..15).
REQ-006 The block SHALL have one clock and a synchronous, active-low reset: isa_clk and isa_reset, reset sampled only on the rising edge of isa_clk.
REQ-007 isa_clk  in  1  ISA bus clock; all logic on its rising edge.
REQ-008 isa_reset  in  1  synchronous active-low reset.
REQ-009 req_valid  in  1  command strobe from the ISA address/IOR/IOW decoder.
REQ-010 req_ready  out  1  high when a command can be accepted.
REQ-011 req_n  in  5  station number; req_a  in  4  subaddress; req_f  in  5  function code.
REQ-012 req_wdata  in  24  write data for F16..F23.
REQ-013 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  24; rsp_q, rsp_x, rsp_err  out  1 each.
REQ-014 isa_chrdy  out  1  ISA channel ready; low inserts wait states while a command is in flight.
REQ-015 camac_n  out  24  one-hot station select, bit k = station k+1; camac_a  out  4; camac_f  out  5.
REQ-016 camac_w  out  24  write bus; camac_r  in  24  read bus; camac_q, camac_x  in  1.
REQ-017 camac_b  out  1  dataway busy; camac_s1, camac_s2  out  1  strobes.

Function
REQ-018 FSM states: IDLE, SETUP, STROBE1, GAP, STROBE2, HOLD, DONE; one 4-bit down-counter reloaded on each state entry.
REQ-019 Accept on the edge where req_valid=1 and req_ready=1; req_ready=1 only in IDLE; req_valid in any other state is ignored, not queued.
REQ-020 On accept, latch N/A/F/W into registers; later input changes do not affect the cycle.
REQ-021 Accept with req_n in 1..23 -> SETUP; with req_n=0 or req_n>=24 -> DONE with rsp_err=1, rsp_q=0, rsp_x=0, rsp_rdata=0, and no dataway activity.
REQ-022 SETUP lasts T_SETUP, STROBE1 T_S1, GAP T_GAP, STROBE2 T_S2, HOLD T_HOLD cycles, then DONE for exactly 1 cycle, then IDLE.
REQ-023 camac_b, camac_n, camac_a, camac_f are driven from SETUP through HOLD inclusive; 0 in IDLE and DONE.
REQ-024 camac_w = latched data during SETUP..HOLD when F is 16..23; else 0.
REQ-025 camac_s1=1 exactly in STROBE1; camac_s2=1 exactly in STROBE2; never both.
REQ-026 camac_q, camac_x sampled on the last cycle of STROBE1; camac_r sampled there too when F is 0..7, else rsp_rdata=0.
REQ-027 In DONE: rsp_valid=1, rsp_err=0 for legal N; rsp_q/rsp_x/rsp_rdata hold their values until the next DONE.
REQ-028 isa_chrdy=0 from the cycle after accept through HOLD; 1 in IDLE and DONE.
REQ-029 Latency with defaults: accept edge to rsp_valid = 10 cycles (2+2+2+2+1 dataway + 1 DONE); illegal N: 1 cycle.
REQ-030 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-031 isa_reset=0 at a rising edge: next state IDLE, counter 0, all camac_* outputs 0, rsp_* 0, req_ready=1, isa_chrdy=1.
REQ-032 Reset mid-cycle (any state) aborts without rsp_valid; S1/S2/B drop on that same edge.
REQ-033 req_valid during reset is ignored.

Verification
REQ-034 Write N=5,A=2,F=16,W=0xA5A5A5 -> camac_n=0x000010, camac_w=0xA5A5A5 for 9 cycles, S1 cycles 3-4, S2 cycles 7-8, rsp_valid on cycle 10, rsp_rdata=0.
REQ-035 Read N=23,A=0,F=0, camac_r=0x123456, Q=1,X=1 -> rsp_rdata=0x123456, rsp_q=1, rsp_x=1, camac_w=0 throughout.
REQ-036 req_n=0 and then req_n=24 -> each gives rsp_valid one cycle after accept, rsp_err=1, camac_b never high.
REQ-037 Second req_valid during STROBE1 -> ignored; exactly one rsp_valid; isa_chrdy low until DONE.
REQ-038 isa_reset=0 asserted during GAP -> next edge all camac_* 0, no rsp_valid, req_ready=1; fresh command then completes normally.
REQ-039 Back-to-back: req_valid held high -> new accept on the IDLE cycle after DONE; camac_b low for exactly 2 cycles between commands.

Source files
------------

// File: rtl/camac_cycle_sequencer.sv
// CAMAC dataway sequencer: one ISA command -> N/A/F setup, S1, gap, S2, hold, then a one-cycle response.
// Latency T_SETUP+T_S1+T_GAP+T_S2+T_HOLD+1 cycles (1 for illegal N); while busy, req_ready=0 and isa_chrdy=0, and nothing is queued.
module camac_cycle_sequencer #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_S1    = 2,
  parameter int unsigned T_GAP   = 2,
  parameter int unsigned T_S2    = 2,
  parameter int unsigned T_HOLD  = 1
) (
  input  logic        isa_clk,
  input  logic        isa_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_n,
  input  logic [3:0]  req_a,
  input  logic [4:0]  req_f,
  input  logic [23:0] req_wdata,
  output logic        rsp_valid,
  output logic [23:0] rsp_rdata,
  output logic        rsp_q,
  output logic        rsp_x,
  output logic        rsp_err,
  output logic        isa_chrdy,
  output logic [23:0] camac_n,
  output logic [3:0]  camac_a,
  output logic [4:0]  camac_f,
  output logic [23:0] camac_w,
  input  logic [23:0] camac_r,
  input  logic        camac_q,
  input  logic        camac_x,
  output logic        camac_b,
  output logic        camac_s1,
  output logic        camac_s2
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE1, GAP, STROBE2, HOLD, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [4:0]  lat_n, n_nxt;
  logic [3:0]  lat_a, a_nxt;
  logic [4:0]  lat_f, f_nxt;
  logic [23:0] lat_w, w_nxt;
  logic        cap_q, cap_x;
  logic [23:0] cap_rdata;
  logic        on_bus, err_done, is_write, sample_s1;
  logic [4:0]  n_idx;
  logic [23:0] n_onehot;

  function automatic logic [3:0] reload(input state_t s);
    case (s)
      SETUP:   reload = 4'(T_SETUP - 1);
      STROBE1: reload = 4'(T_S1 - 1);
      GAP:     reload = 4'(T_GAP - 1);
      STROBE2: reload = 4'(T_S2 - 1);
      HOLD:    reload = 4'(T_HOLD - 1);
      default: reload = 4'd0;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    n_nxt     = lat_n;
    a_nxt     = lat_a;
    f_nxt     = lat_f;
    w_nxt     = lat_w;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          n_nxt = req_n;
          a_nxt = req_a;
          f_nxt = req_f;
          w_nxt = req_wdata;
          if (req_n != 5'd0 && req_n < 5'd24) state_nxt = SETUP;
          else                                state_nxt = DONE;
        end
      end
      SETUP:   if (cnt == 4'd0) state_nxt = STROBE1;
      STROBE1: if (cnt == 4'd0) state_nxt = GAP;
      GAP:     if (cnt == 4'd0) state_nxt = STROBE2;
      STROBE2: if (cnt == 4'd0) state_nxt = HOLD;
      HOLD:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Every transition is a state entry, so reload on any change of state.
    if (state_nxt != state) cnt_nxt = reload(state_nxt);
    else if (cnt != 4'd0)   cnt_nxt = cnt - 4'd1;
    else                    cnt_nxt = cnt;
  end

  always_comb begin
    on_bus    = (state_nxt == SETUP) || (state_nxt == STROBE1) || (state_nxt == GAP) ||
                (state_nxt == STROBE2) || (state_nxt == HOLD);
    err_done  = (state == IDLE) && (state_nxt == DONE);
    is_write  = (f_nxt[4:3] == 2'b10);
    sample_s1 = (state == STROBE1) && (cnt == 4'd0);
    n_idx     = n_nxt - 5'd1;
    n_onehot  = 24'd1 << n_idx;
  end

  // Outputs are registered from next-state values so they line up with the state register.
  always_ff @(posedge isa_clk) begin
    if (!isa_reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_n     <= 5'd0;
      lat_a     <= 4'd0;
      lat_f     <= 5'd0;
      lat_w     <= 24'd0;
      cap_q     <= 1'b0;
      cap_x     <= 1'b0;
      cap_rdata <= 24'd0;
      req_ready <= 1'b1;
      isa_chrdy <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 24'd0;
      rsp_q     <= 1'b0;
      rsp_x     <= 1'b0;
      rsp_err   <= 1'b0;
      camac_b   <= 1'b0;
      camac_n   <= 24'd0;
      camac_a   <= 4'd0;
      camac_f   <= 5'd0;
      camac_w   <= 24'd0;
      camac_s1  <= 1'b0;
      camac_s2  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lat_n     <= n_nxt;
      lat_a     <= a_nxt;
      lat_f     <= f_nxt;
      lat_w     <= w_nxt;
      req_ready <= (state_nxt == IDLE);
      isa_chrdy <= !on_bus;
      camac_b   <= on_bus;
      camac_n   <= on_bus ? n_onehot : 24'd0;
      camac_a   <= on_bus ? a_nxt : 4'd0;
      camac_f   <= on_bus ? f_nxt : 5'd0;
      camac_w   <= (on_bus && is_write) ? w_nxt : 24'd0;
      camac_s1  <= (state_nxt == STROBE1);
      camac_s2  <= (state_nxt == STROBE2);
      rsp_valid <= (state_nxt == DONE);

      if (sample_s1) begin
        cap_q     <= camac_q;
        cap_x     <= camac_x;
        cap_rdata <= (lat_f[4:3] == 2'b00) ? camac_r : 24'd0;
      end

      // Response fields change only when entering DONE and hold until the next one.
      if (state_nxt == DONE) begin
        rsp_err   <= err_done;
        rsp_q     <= err_done ? 1'b0  : cap_q;
        rsp_x     <= err_done ? 1'b0  : cap_x;
        rsp_rdata <= err_done ? 24'd0 : cap_rdata;
      end
    end
  end

endmodule

// File: tb/tb_camac_cycle_sequencer.sv
// Directed bench for camac_cycle_sequencer: per-cycle dataway checks plus a response scoreboard.
module tb_camac_cycle_sequencer;

  logic        isa_clk, isa_reset;
  logic        req_valid, req_ready;
  logic [4:0]  req_n;
  logic [3:0]  req_a;
  logic [4:0]  req_f;
  logic [23:0] req_wdata;
  logic        rsp_valid, rsp_q, rsp_x, rsp_err, isa_chrdy;
  logic [23:0] rsp_rdata;
  logic [23:0] camac_n, camac_w, camac_r;
  logic [3:0]  camac_a;
  logic [4:0]  camac_f;
  logic        camac_q, camac_x, camac_b, camac_s1, camac_s2;

  typedef struct packed {
    logic [23:0] rdata;
    logic        q;
    logic        x;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_rsp    = 0;

  camac_cycle_sequencer dut (
    .isa_clk(isa_clk), .isa_reset(isa_reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_n(req_n), .req_a(req_a), .req_f(req_f), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_q(rsp_q), .rsp_x(rsp_x), .rsp_err(rsp_err),
    .isa_chrdy(isa_chrdy),
    .camac_n(camac_n), .camac_a(camac_a), .camac_f(camac_f), .camac_w(camac_w),
    .camac_r(camac_r), .camac_q(camac_q), .camac_x(camac_x),
    .camac_b(camac_b), .camac_s1(camac_s1), .camac_s2(camac_s2)
  );

  initial isa_clk = 1'b0;
  always #5 isa_clk = ~isa_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one cycle, sample 1ns after the edge, and retire any response against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge isa_clk);
    #1;
    if (rsp_valid === 1'b1) begin
      n_rsp++;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(sb.size() != 0), 32'd1);
      end else begin
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_q", rsp_q, e.q);
        check("rsp_x", rsp_x, e.x);
        check("rsp_err", rsp_err, e.err);
      end
    end
  endtask

  task automatic run_cmd(input logic [4:0] n, input logic [3:0] a, input logic [4:0] f,
                         input logic [23:0] w, input logic [23:0] onehot,
                         input logic [23:0] r, input logic q, input logic x,
                         input logic [23:0] exp_rdata, input logic legal, input logic poke);
    int   last;
    logic bus, wr;
    last = legal ? 10 : 1;
    wr   = (f >= 5'd16) && (f <= 5'd23);
    sb.push_back('{rdata: exp_rdata, q: legal ? q : 1'b0, x: legal ? x : 1'b0, err: !legal});
    camac_r   = ~r;
    camac_q   = ~q;
    camac_x   = ~x;
    req_n     = n;
    req_a     = a;
    req_f     = f;
    req_wdata = w;
    req_valid = 1'b1;
    for (int c = 1; c <= last; c++) begin
      tick();
      if (c == 1) begin
        req_valid = 1'b0;
        req_n     = 5'd7;
        req_a     = ~a;
        req_f     = ~f;
        req_wdata = ~w;
      end
      if (poke && c == 3) req_valid = 1'b1;
      if (poke && c == 5) req_valid = 1'b0;
      if (c == 4) begin camac_r = r;  camac_q = q;  camac_x = x;  end
      if (c == 5) begin camac_r = ~r; camac_q = ~q; camac_x = ~x; end
      bus = legal && (c <= 9);
      check("camac_b", camac_b, bus);
      check("camac_n", camac_n, bus ? onehot : 24'd0);
      check("camac_a", camac_a, bus ? a : 4'd0);
      check("camac_f", camac_f, bus ? f : 5'd0);
      check("camac_w", camac_w, (bus && wr) ? w : 24'd0);
      check("camac_s1", camac_s1, legal && (c == 3 || c == 4));
      check("camac_s2", camac_s2, legal && (c == 7 || c == 8));
      check("isa_chrdy", isa_chrdy, !bus);
      check("req_ready", req_ready, 1'b0);
      check("rsp_valid", rsp_valid, c == last);
    end
    tick();
    check("idle_ready", req_ready, 1'b1);
    check("idle_rsp", rsp_valid, 1'b0);
    check("idle_b", camac_b, 1'b0);
  endtask

  initial begin
    int rsp0;
    isa_reset = 1'b0;
    req_valid = 1'b1;
    req_n     = 5'd5;
    req_a     = 4'd2;
    req_f     = 5'd16;
    req_wdata = 24'h0F0F0F;
    camac_r   = 24'h0;
    camac_q   = 1'b0;
    camac_x   = 1'b0;

    // Reset with req_valid held high: nothing may be accepted.
    tick();
    tick();
    check("rst_ready", req_ready, 1'b1);
    check("rst_chrdy", isa_chrdy, 1'b1);
    check("rst_b", camac_b, 1'b0);
    check("rst_n", camac_n, 24'd0);
    check("rst_s1", camac_s1, 1'b0);
    check("rst_rsp", rsp_valid, 1'b0);
    check("rst_err", rsp_err, 1'b0);
    isa_reset = 1'b1;
    req_valid = 1'b0;
    tick();
    check("post_rst_ready", req_ready, 1'b1);
    check("post_rst_b", camac_b, 1'b0);

    // Write, read, read with an ignored second request, and a non-data function.
    run_cmd(5'd5,  4'd2,  5'd16, 24'hA5A5A5, 24'h000010, 24'h777777, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b0);
    run_cmd(5'd23, 4'd0,  5'd0,  24'h0000FF, 24'h400000, 24'h123456, 1'b1, 1'b1, 24'h123456, 1'b1, 1'b0);
    run_cmd(5'd1,  4'd15, 5'd7,  24'h00AA00, 24'h000001, 24'hFEDCBA, 1'b1, 1'b0, 24'hFEDCBA, 1'b1, 1'b1);
    run_cmd(5'd12, 4'd3,  5'd8,  24'h111111, 24'h000800, 24'h333333, 1'b1, 1'b1, 24'h000000, 1'b1, 1'b0);

    // Illegal station numbers.
    run_cmd(5'd0,  4'd1, 5'd16, 24'h222222, 24'h0, 24'h0, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0);
    run_cmd(5'd24, 4'd1, 5'd0,  24'h222222, 24'h0, 24'h0, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0);
    run_cmd(5'd31, 4'd1, 5'd17, 24'h222222, 24'h0, 24'h0, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0);

    // Reset while in GAP aborts with no response.
    req_n     = 5'd5;
    req_a     = 4'd4;
    req_f     = 5'd16;
    req_wdata = 24'h5A5A5A;
    req_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
    end
    check("gap_b", camac_b, 1'b1);
    check("gap_s1", camac_s1, 1'b0);
    check("gap_s2", camac_s2, 1'b0);
    isa_reset = 1'b0;
    tick();
    isa_reset = 1'b1;
    check("abort_b", camac_b, 1'b0);
    check("abort_n", camac_n, 24'd0);
    check("abort_w", camac_w, 24'd0);
    check("abort_s1", camac_s1, 1'b0);
    check("abort_s2", camac_s2, 1'b0);
    check("abort_rsp", rsp_valid, 1'b0);
    check("abort_ready", req_ready, 1'b1);
    check("abort_chrdy", isa_chrdy, 1'b1);
    for (int c = 0; c < 12; c++) tick();
    check("abort_quiet_b", camac_b, 1'b0);
    run_cmd(5'd5, 4'd4, 5'd16, 24'h5A5A5A, 24'h000010, 24'h0, 1'b1, 1'b1, 24'h0, 1'b1, 1'b0);

    // Back-to-back with req_valid held: exactly two idle-bus cycles between commands.
    rsp0      = n_rsp;
    camac_r   = 24'h999999;
    camac_q   = 1'b1;
    camac_x   = 1'b0;
    req_n     = 5'd1;
    req_a     = 4'd1;
    req_f     = 5'd17;
    req_wdata = 24'h000001;
    sb.push_back('{rdata: 24'h0, q: 1'b1, x: 1'b0, err: 1'b0});
    sb.push_back('{rdata: 24'h0, q: 1'b1, x: 1'b0, err: 1'b0});
    req_valid = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 12) req_valid = 1'b0;
      check("b2b_b", camac_b, (c <= 9) || (c >= 12 && c <= 20));
      if (c == 12) check("b2b_n", camac_n, 24'h000001);
    end
    check("b2b_rsp_count", n_rsp - rsp0, 32'd2);
    check("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
